// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default operand width and FSM encodings.
package serial_adder_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        SADD_IDLE = 2'b00,
        SADD_RUN  = 2'b01,
        SADD_FIN  = 2'b10
    } sadd_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Start/done operand and result bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the sub request line.
interface serial_adder_if #(
    parameter int DATA_WIDTH = serial_adder_pkg::DEFAULT_DATA_WIDTH
);

    logic                  start;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  ci;
`ifdef SERIAL_ADDER_SUB_EN
    logic                  sub;
`endif
    logic [DATA_WIDTH-1:0] y;
    logic                  co;
    logic                  busy;
    logic                  done;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, ci,
        input  y, co, busy, done
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b, ci,
        output y, co, busy, done
    );

endinterface : serial_adder_if

// File: rtl/serial_adder_full_adder.sv
// Full adder built from two half-adder cells and an OR of their carries.
module serial_adder_full_adder (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    logic s1;
    logic c1;
    logic c2;

    serial_adder_half_adder u_ha0 (
        .s (s1),
        .c (c1),
        .a (a),
        .b (b)
    );

    serial_adder_half_adder u_ha1 (
        .s (s),
        .c (c2),
        .a (s1),
        .b (ci)
    );

    assign co = c1 | c2;

endmodule : serial_adder_full_adder

// File: rtl/serial_adder_half_adder.sv
// Half-adder cell: sum and carry of two bits.
module serial_adder_half_adder (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : serial_adder_half_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per clock through a single full adder, start/done handshake.
// Optional SERIAL_ADDER_SUB_EN turns the captured sub request into A - B.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);

    localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    sadd_state_e           state;
    sadd_state_e           state_next;
    logic                  accept;
    logic                  last;

    logic [DATA_WIDTH-1:0] a_sr;
    logic [DATA_WIDTH-1:0] b_sr;
    logic [DATA_WIDTH-1:0] y_q;
    logic                  carry_q;
    logic                  co_q;
    logic [CNT_W-1:0]      cnt;

    logic [DATA_WIDTH-1:0] b_load;
    logic                  carry_load;
    logic                  fa_s;
    logic                  fa_co;

    // Subtraction is A + ~B + 1, so only the B load value and the initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1   : bus.ci;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.ci;
`endif

    serial_adder_full_adder u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_q)
    );

    assign last = (cnt == LAST_BIT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SADD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            SADD_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SADD_RUN;
                end
            end
            SADD_RUN: begin
                if (last) begin
                    state_next = SADD_FIN;
                end
            end
            SADD_FIN: begin
                accept     = bus.start;
                state_next = bus.start ? SADD_RUN : SADD_IDLE;
            end
            default: begin
                state_next = SADD_IDLE;
            end
        endcase
    end

    // NOTE: these are plain registers, not a RAM array, so they take the synchronous reset like any flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= b_load;
            carry_q <= carry_load;
            y_q     <= '0;
            cnt     <= '0;
        end else if (state == SADD_RUN) begin
            // LSB-first: each sum bit enters at the MSB, so after DATA_WIDTH shifts it sits in place.
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            y_q     <= {fa_s, y_q[DATA_WIDTH-1:1]};
            carry_q <= fa_co;
            cnt     <= cnt + 1'b1;
            if (last) begin
                co_q <= fa_co;
            end
        end
    end

    // Status flags decode the state register directly, so no input reaches an output combinationally.
    assign bus.y    = y_q;
    assign bus.co   = co_q;
    assign bus.busy = (state == SADD_RUN);
    assign bus.done = (state == SADD_FIN);

endmodule : serial_adder

// File: doc/serial_adder.md
# serial_adder

- Bit-serial adder: adds two `DATA_WIDTH`-bit operands one bit per clock through a single `FULL_ADDER` (two `HALF_ADDER`s plus an OR) and a registered carry.
- Sits directly downstream of the half-adder cells and consumes their sum/carry outputs.
- Provides a low-area, multi-cycle add path for the ALU and for the sequential multiplier.
- Handshake is start/done; the result holds until the next operation.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RST` input 1: reset; synchronous, active-high.
- `START` input 1: request to begin an add; sampled on the rising edge.
- `A` input `DATA_WIDTH`: operand A; captured only on an accepted `START`.
- `B` input `DATA_WIDTH`: operand B; captured only on an accepted `START`.
- `CI` input 1: carry-in; captured only on an accepted `START`.
- `Y` output `DATA_WIDTH`: sum; valid while `DONE` is high and held afterwards.
- `CO` output 1: final carry-out; same validity as `Y`.
- `BUSY` output 1: high in the RUN state.
- `DONE` output 1: one-cycle pulse marking the result valid.

## Operation
- States: IDLE, RUN, FIN. Reset state is IDLE.
- Reset values: `Y=0`, `CO=0`, `BUSY=0`, `DONE=0`. Internal shift registers, carry register and bit counter are all cleared.
- IDLE or FIN with `START=1`:
  - Load `A`/`B` shift registers and carry register ← `CI`.
  - Clear the counter and `Y`; go to RUN.
- IDLE with `START=0`: stay in IDLE.
- FIN with `START=0`: go to IDLE.
- RUN, every cycle:
  - The full adder takes `a_sr[0]`, `b_sr[0]` and the carry register.
  - Sum bit shifts into `Y` at the MSB; `Y` shifts right.
  - Operand registers shift right; carry register ← full-adder carry; counter increments.
- RUN → FIN when the counter reaches `DATA_WIDTH-1` on that edge, i.e. after exactly `DATA_WIDTH` RUN edges.
- On the RUN → FIN edge, `CO` ← final carry.
- `START` during RUN is ignored. Operands are not re-sampled and no error is raised.
- Arithmetic: `{CO,Y} = A + B + CI`, modulo 2^(`DATA_WIDTH`+1). No signed interpretation; overflow is left to the consumer.
- `RST` high in any state, including mid-RUN, returns to IDLE with all reset values on that edge. The partial result is discarded.
- `RST` and `START` asserted together: `RST` wins.

## Timing
- `START` accepted at edge 0 → `BUSY` high from edge 0 to edge `DATA_WIDTH`.
- `DONE` is high for exactly one cycle, from edge `DATA_WIDTH` to edge `DATA_WIDTH+1`. With the default, `DONE` rises 32 cycles after acceptance.
- Back-to-back: `START` high during the `DONE` cycle is accepted. `DONE` falls and `BUSY` rises on the same edge, with no dead cycle.
- `Y` bits are partial during RUN; consumers use `Y`/`CO` only when `DONE`=1 or later.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_ADDER_SUB_EN`.
- Defined:
  - Adds input `SUB` (1 bit), captured on an accepted `START`.
  - When captured `SUB=1`: the `B` shift register loads `~B` and the carry register loads 1; `CI` is ignored.
  - Result is `A - B`; `CO=1` means no borrow.
- Undefined: no `SUB` port; add only, as above.

## Structure
- Shared `prj_definition.v` holds:
  - `DATA_WIDTH` (default source).
  - State encodings `SADD_IDLE=2'b00`, `SADD_RUN=2'b01`, `SADD_FIN=2'b10`.
- Counter width is `$clog2(DATA_WIDTH)`, computed locally.
- One sub-module: `FULL_ADDER(S,CO,A,B,CI)`, built from two `HALF_ADDER` instances and an OR of their carries. It is reused by later adder blocks.

## Test plan
- Reset then idle 5 cycles → all outputs 0, `BUSY=0`, `DONE=0`.
- `A=32'h12345678`, `B=32'h11111111`, `CI=0`, `START` one cycle → `DONE` pulse 32 cycles later, `Y=32'h23456789`, `CO=0`.
- `A=32'hFFFFFFFF`, `B=0`, `CI=1` → `Y=0`, `CO=1`. Then `START` in the `DONE` cycle with `A=B=32'h80000000`, `CI=0` → `Y=0`, `CO=1` after 32 more cycles.
- `START` with `A=1`, `B=2`; pulse `START` again at RUN cycle 10 with `A=B=32'hFFFF` → first result `Y=3` and `DONE` still arrives at cycle 32.
- Assert `RST` at RUN cycle 15 → next cycle IDLE with all outputs 0. A new `START` with `A=B=7` gives `Y=14`.
- `SERIAL_ADDER_SUB_EN` defined: `A=5`, `B=7`, `SUB=1` → `Y=32'hFFFFFFFE`, `CO=0`. `A=7`, `B=5` → `Y=2`, `CO=1`.
